// File: rtl/fp32_pkg.sv
// Shared single-precision constants, field widths and sequencer state type
// for the shift-add float multiplier.
package fp32_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int PROD_W = 48;
  localparam int CNT_W  = 5;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } state_t;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
  } fp_class_t;
endpackage

// File: rtl/fp32_classify.sv
// Operand classifier: zero (subnormals flushed), infinity and NaN flags.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0] x,
  output fp_class_t   cls
);

  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] f;

  assign e = x[30:23];
  assign f = x[FRAC_W-1:0];

  always_comb begin
    cls      = '0;
    cls.zero = (e == '0);
    cls.inf  = (e == '1) && (f == '0);
    cls.nan  = (e == '1) && (f != '0);
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single multiplier: 24-step shift-add mantissa product,
// then one normalize/round cycle; specials resolve straight to DONE.
module fp_mul_seq
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] MulProd,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic signed [9:0] EMAX = 10'(EXP_MAX);

  state_t              state;
  logic                sa, sb;
  logic [EXP_W-1:0]    ea, eb;
  logic [MANT_W-1:0]   ma, mb;
  logic [PROD_W-1:0]   prod;
  logic [CNT_W-1:0]    cnt;

  fp_class_t           ca, cb;
  logic                spec;
  logic                s_in;
  logic [31:0]         spec_res;

  logic [PROD_W-1:0]   pp;
  logic [MANT_W-1:0]   mant;
  logic                g, r, s, up;
  logic [MANT_W:0]     mant_r;
  logic signed [9:0]   exp_n, exp_f;
  logic                sgn;
  logic [31:0]         norm_res;

  fp32_classify u_cls_a (.x(A), .cls(ca));
  fp32_classify u_cls_b (.x(B), .cls(cb));

  assign in_ready = (state == IDLE);
  assign s_in     = A[31] ^ B[31];
  assign spec     = ca.zero | ca.inf | ca.nan
                  | cb.zero | cb.inf | cb.nan;

  always_comb begin
    spec_res = {s_in, 31'b0};
    if (ca.nan || cb.nan || (ca.inf && cb.zero) || (ca.zero && cb.inf))
      spec_res = QNAN;
    else if (ca.inf || cb.inf)
      spec_res = {s_in, 8'hFF, 23'b0};
  end

  assign pp = mb[cnt] ? ({{(PROD_W-MANT_W){1'b0}}, ma} << cnt) : '0;

  // Product lies in [1,4): bit 47 selects a one-place right normalize.
  always_comb begin
    sgn   = sa ^ sb;
    exp_n = 10'(ea) + 10'(eb) - 10'(BIAS) + {9'b0, prod[47]};
    if (prod[47]) begin
      mant = prod[47:24];
      g    = prod[23];
      r    = prod[22];
      s    = |prod[21:0];
    end else begin
      mant = prod[46:23];
      g    = prod[22];
      r    = prod[21];
      s    = |prod[20:0];
    end
    up     = g & (r | s | mant[0]);
    mant_r = {1'b0, mant} + {{MANT_W{1'b0}}, up};
    exp_f  = exp_n + {9'b0, mant_r[MANT_W]};
    if (exp_f >= EMAX)
      norm_res = {sgn, 8'hFF, 23'b0};
    else if (exp_f <= 10'sd0)
      norm_res = {sgn, 31'b0};
    else if (mant_r[MANT_W])
      norm_res = {sgn, exp_f[7:0], mant_r[MANT_W-1:1]};
    else
      norm_res = {sgn, exp_f[7:0], mant_r[FRAC_W-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      MulProd   <= '0;
      out_valid <= 1'b0;
      cnt       <= '0;
      prod      <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      ea        <= '0;
      eb        <= '0;
      ma        <= '0;
      mb        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sa <= A[31];
            sb <= B[31];
            ea <= A[30:23];
            eb <= B[30:23];
            ma <= {1'b1, A[FRAC_W-1:0]};
            mb <= {1'b1, B[FRAC_W-1:0]};
            if (spec) begin
              MulProd   <= spec_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              prod  <= '0;
              cnt   <= '0;
              state <= MUL;
            end
          end
        end
        MUL: begin
          prod <= prod + pp;
          if (cnt == 5'd23) begin
            cnt   <= '0;
            state <= NORM;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        NORM: begin
          MulProd   <= norm_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed-vector bench for fp_mul_seq: results, latency, hold and reset.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] MulProd;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  fp_mul_seq dut (
    .clk(clk),
    .rst(rst),
    .A(A),
    .B(B),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .MulProd(MulProd),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start(input string tag, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    check({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_idle"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run_norm(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    int n;
    start(tag, a, b);
    wait_done(n);
    check({tag, "_lat"}, 32'(n), 32'd25);
    check(tag, MulProd, exp);
    take(tag);
  endtask

  task automatic run_spec(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    start(tag, a, b);
    check({tag, "_ov"}, {31'b0, out_valid}, 32'd1);
    check(tag, MulProd, exp);
    take(tag);
  endtask

  initial begin
    int n;
    #2;
    check("rst_prod", MulProd, 32'h0);
    check("rst_ov", {31'b0, out_valid}, 32'd0);
    check("rst_rdy", {31'b0, in_ready}, 32'd1);
    #10 rst = 1'b0;

    run_norm("two_x_three", 32'h40000000, 32'h40400000, 32'h40C00000);
    run_norm("neg_x_three", 32'hC0000000, 32'h40400000, 32'hC0C00000);
    run_norm("norm_shift", 32'h3FC00000, 32'h3FC00000, 32'h40100000);
    run_norm("round_lsb", 32'h3F800001, 32'h3F800001, 32'h3F800002);
    run_norm("near_two_sq", 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);
    run_norm("overflow", 32'h7F000000, 32'h7F000000, 32'h7F800000);
    run_norm("underflow", 32'h00800000, 32'h00800000, 32'h00000000);

    run_spec("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000);
    run_spec("ninf_x_two", 32'hFF800000, 32'h40000000, 32'hFF800000);
    run_spec("nan_in", 32'h7FC12345, 32'h3F800000, 32'h7FC00000);
    run_spec("negz_x_two", 32'h80000000, 32'h40000000, 32'h80000000);
    run_spec("sub_flush", 32'h00000001, 32'hC0000000, 32'h80000000);

    // hold in DONE with out_ready low while new operands are offered
    start("hold", 32'h40000000, 32'h40400000);
    wait_done(n);
    check("hold_lat", 32'(n), 32'd25);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      A = 32'h3FC00000;
      B = 32'h3FC00000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("hold_ov", {31'b0, out_valid}, 32'd1);
      check("hold_prod", MulProd, 32'h40C00000);
      check("hold_rdy", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    take("hold");
    repeat (3) @(posedge clk);
    #1;
    check("no_queue_ov", {31'b0, out_valid}, 32'd0);
    check("no_queue_rdy", {31'b0, in_ready}, 32'd1);

    // reset pulse while the multiplier is at step 10
    start("mid_rst", 32'h40000000, 32'h40400000);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ov", {31'b0, out_valid}, 32'd0);
    check("mid_rst_prod", MulProd, 32'h0);
    check("mid_rst_rdy", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_norm("after_rst", 32'h3FC00000, 32'h3FC00000, 32'h40100000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
